// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with operand muxing
// and an iterative unsigned multiply/divide unit.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  output logic             Ready,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  input  logic [WIDTH-1:0] ImmExt,
  input  logic [3:0]       ALUControl,
  input  logic             ALUSrcA,
  input  logic             ALUSrcB,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Done
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  localparam logic [3:0] OP_MUL   = 4'b1011;
  localparam logic [3:0] OP_MULHU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REMU  = 4'b1110;

  state_t state, state_nx;

  logic [WIDTH-1:0]   src_a, src_b;
  logic [WIDTH-1:0]   res_alu;
  logic               is_mul, is_div;
  logic [3:0]         op;
  logic [WIDTH-1:0]   opd;
  logic [2*WIDTH-1:0] acc;
  logic [SHW-1:0]     cnt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx;
  logic [WIDTH:0]     div_sh, div_df;
  logic [2*WIDTH-1:0] div_nx;
  logic               load;
  logic [WIDTH-1:0]   load_val;

  assign src_a = ALUSrcA ? PC : RD1;
  assign src_b = ALUSrcB ? ImmExt : RD2;

  assign is_mul = (ALUControl == OP_MUL) || (ALUControl == OP_MULHU);
  assign is_div = (ALUControl == OP_DIVU) || (ALUControl == OP_REMU);

  assign Ready = (state == IDLE);
  assign Done  = (state == DONE);

  // Single-cycle result; division by zero resolves here too.
  always_comb begin
    res_alu = '0;
    case (ALUControl)
      4'b0000: res_alu = src_a + src_b;
      4'b0001: res_alu = src_a - src_b;
      4'b0010: res_alu = src_a & src_b;
      4'b0011: res_alu = src_a | src_b;
      4'b0100: res_alu = src_a >> src_b[SHW-1:0];
      4'b0101: res_alu = {{(WIDTH-1){1'b0}},
                          $signed(src_a) < $signed(src_b)};
      4'b0110: res_alu = src_b;
      4'b0111: res_alu = src_a << src_b[SHW-1:0];
      4'b1000: res_alu = src_a ^ src_b;
      4'b1001: res_alu = {{(WIDTH-1){1'b0}}, src_a < src_b};
      4'b1010: res_alu = $unsigned($signed(src_a)
                                   >>> src_b[SHW-1:0]);
      4'b1101: res_alu = '1;
      4'b1110: res_alu = src_a;
      default: res_alu = '0;
    endcase
  end

  // One shift-add step and one restoring-divide step.
  // acc holds {partial product, multiplier} for MUL
  // and {remainder, dividend/quotient} for DIV.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
            + (acc[0] ? {1'b0, opd} : '0);
    mul_nx  = {mul_sum, acc[WIDTH-1:1]};
    div_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_df  = div_sh - {1'b0, opd};
    if (div_df[WIDTH])
      div_nx = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_nx = {div_df[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Next state and result-load decision.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_val = '0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          if (is_mul) begin
            state_nx = MUL;
          end else if (is_div && (src_b != '0)) begin
            state_nx = DIV;
          end else begin
            state_nx = DONE;
            load     = 1'b1;
            load_val = res_alu;
          end
        end
      end
      MUL: begin
        if (&cnt) begin
          state_nx = DONE;
          load     = 1'b1;
          load_val = (op == OP_MULHU)
                   ? mul_nx[2*WIDTH-1:WIDTH]
                   : mul_nx[WIDTH-1:0];
        end
      end
      DIV: begin
        if (&cnt) begin
          state_nx = DONE;
          load     = 1'b1;
          load_val = (op == OP_REMU)
                   ? div_nx[2*WIDTH-1:WIDTH]
                   : div_nx[WIDTH-1:0];
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op        <= '0;
      opd       <= '0;
      acc       <= '0;
      cnt       <= '0;
      ALUResult <= '0;
      Zero      <= 1'b1;
    end else begin
      if (state == IDLE && Start) begin
        op  <= ALUControl;
        cnt <= '0;
        if (is_mul) begin
          opd <= src_a;
          acc <= {{WIDTH{1'b0}}, src_b};
        end else begin
          opd <= src_b;
          acc <= {{WIDTH{1'b0}}, src_a};
        end
      end else if (state == MUL) begin
        acc <= mul_nx;
        cnt <= cnt + SHW'(1);
      end else if (state == DIV) begin
        acc <= div_nx;
        cnt <= cnt + SHW'(1);
      end
      if (load) begin
        ALUResult <= load_val;
        Zero      <= (load_val == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: random and directed checks of alu_seq
// against a cycle-level behavioural model.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         Start = 1'b0;
  logic         Ready;
  logic [W-1:0] PC = '0;
  logic [W-1:0] RD1 = '0;
  logic [W-1:0] RD2 = '0;
  logic [W-1:0] ImmExt = '0;
  logic [3:0]   ALUControl = '0;
  logic         ALUSrcA = 1'b0;
  logic         ALUSrcB = 1'b0;
  logic [W-1:0] ALUResult;
  logic         Zero;
  logic         Done;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Start      (Start),
    .Ready      (Ready),
    .PC         (PC),
    .RD1        (RD1),
    .RD2        (RD2),
    .ImmExt     (ImmExt),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .Done       (Done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint unsigned p;
    int sa;
    int sb;
    int sh;
    logic [31:0] r;
    p  = longint'(a) * longint'(b);
    sa = a;
    sb = b;
    sh = int'(b[4:0]);
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a >> sh;
      4'd5:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6:  r = b;
      4'd7:  r = a << sh;
      4'd8:  r = a ^ b;
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
      4'd10: r = sa >>> sh;
      4'd11: r = p[31:0];
      4'd12: r = p[63:32];
      4'd13: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: r = (b == 0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(
    input logic [3:0] op,
    input logic [31:0] b
  );
    if (op == 4'd11 || op == 4'd12) return W + 1;
    if ((op == 4'd13 || op == 4'd14) && b != 0) return W + 1;
    return 1;
  endfunction

  // Behavioural model: countdown to the Done cycle.
  int          m_rem = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;
  bit          m_ready_was;
  logic [31:0] m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_res  = '0;
    end else begin
      m_ready_was = (m_rem == 0) && !m_done;
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_done = 1'b1;
          m_res  = m_pend;
        end
      end else begin
        m_done = 1'b0;
      end
      if (m_ready_was && Start) begin
        m_a    = ALUSrcA ? PC : RD1;
        m_b    = ALUSrcB ? ImmExt : RD2;
        m_pend = ref_op(ALUControl, m_a, m_b);
        m_rem  = ref_lat(ALUControl, m_b) - 1;
        if (m_rem == 0) begin
          m_done = 1'b1;
          m_res  = m_pend;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      n_tests++;
      if (Done !== m_done
          || Ready !== ((m_rem == 0) && !m_done)
          || ALUResult !== m_res
          || Zero !== (m_res == 0)) begin
        n_fail++;
        $display("FAIL cycle t=%0t: Done=%b/%b Ready=%b/%b Res=%h/%h Zero=%b/%b",
                 $time, Done, m_done, Ready,
                 (m_rem == 0) && !m_done, ALUResult, m_res,
                 Zero, (m_res == 0));
      end
    end
  end

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(
    input logic [3:0] op,
    input logic sa,
    input logic sb,
    input logic [31:0] pc,
    input logic [31:0] rd1,
    input logic [31:0] rd2,
    input logic [31:0] imm,
    input bit noisy,
    output logic [31:0] res,
    output int lat
  );
    int g;
    g = 0;
    while (!Ready && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (!Ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_wait: got 0 expected 1");
    end
    ALUControl = op;
    ALUSrcA    = sa;
    ALUSrcB    = sb;
    PC         = pc;
    RD1        = rd1;
    RD2        = rd2;
    ImmExt     = imm;
    Start      = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    lat = 1;
    while (!Done && lat < 200) begin
      if (noisy) begin
        Start = 1'($urandom_range(0, 1));
        RD1   = $urandom;
        RD2   = $urandom;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    Start = 1'b0;
    res = ALUResult;
  endtask

  logic [31:0] res;
  int          lat;
  int          seen;
  logic [3:0]  rop;
  logic [31:0] ra, rb, rpc, rimm, ea, eb;
  logic        rsa, rsb;

  initial begin
    #300_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("reset_result", ALUResult, 32'h0);
    chk("reset_zero", {31'b0, Zero}, 32'd1);
    chk("reset_done", {31'b0, Done}, 32'd0);
    chk("reset_ready", {31'b0, Ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("model_mulhu", ref_op(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
        32'hFFFF_FFFE);
    chk("model_sra", ref_op(4'd10, 32'h8000_0000, 32'd4),
        32'hF800_0000);
    chk("model_slt", ref_op(4'd5, 32'hFFFF_FFFF, 32'd1), 32'd1);

    do_op(4'd0, 0, 1, 0, 5, 0, 32'hFFFF_FFFB, 0, res, lat);
    chk("add_res", res, 32'h0);
    chk("add_zero", {31'b0, Zero}, 32'd1);
    chk("add_lat", lat, 1);
    do_op(4'd5, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, res, lat);
    chk("slt", res, 32'd1);
    do_op(4'd9, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, res, lat);
    chk("sltu", res, 32'd0);
    do_op(4'd10, 0, 0, 0, 32'h8000_0000, 4, 0, 0, res, lat);
    chk("sra", res, 32'hF800_0000);
    do_op(4'd4, 0, 0, 0, 32'h8000_0000, 4, 0, 0, res, lat);
    chk("srl", res, 32'h0800_0000);
    do_op(4'd11, 0, 0, 0, 7, 6, 0, 1, res, lat);
    chk("mul_res", res, 32'd42);
    chk("mul_lat", lat, 33);
    do_op(4'd12, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,
          res, lat);
    chk("mulhu", res, 32'hFFFF_FFFE);
    do_op(4'd13, 0, 0, 0, 100, 7, 0, 1, res, lat);
    chk("divu_res", res, 32'd14);
    chk("divu_lat", lat, 33);
    do_op(4'd14, 0, 0, 0, 100, 7, 0, 0, res, lat);
    chk("remu_res", res, 32'd2);
    chk("remu_lat", lat, 33);
    do_op(4'd13, 0, 0, 0, 9, 0, 0, 0, res, lat);
    chk("divu0_res", res, 32'hFFFF_FFFF);
    chk("divu0_lat", lat, 1);
    do_op(4'd14, 0, 0, 0, 9, 0, 0, 0, res, lat);
    chk("remu0_res", res, 32'd9);

    // Back-to-back: Start held high across Done.
    @(posedge clk);
    #1;
    ALUControl = 4'd1;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 1'b0;
    RD1        = 10;
    RD2        = 3;
    Start      = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_first_done", {31'b0, Done}, 32'd1);
    chk("b2b_first_res", ALUResult, 32'd7);
    ALUControl = 4'd11;
    RD1        = 3;
    RD2        = 5;
    @(posedge clk);
    #1;
    chk("b2b_ready", {31'b0, Ready}, 32'd1);
    @(posedge clk);
    #1;
    Start = 1'b0;
    chk("b2b_accepted", {31'b0, Ready}, 32'd0);
    chk("b2b_hold", ALUResult, 32'd7);
    lat = 1;
    while (!Done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_second_lat", lat, 33);
    chk("b2b_second_res", ALUResult, 32'd15);

    // Reset in the middle of a multiply.
    @(posedge clk);
    #1;
    ALUControl = 4'd11;
    RD1        = 123;
    RD2        = 456;
    Start      = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_result", ALUResult, 32'h0);
    chk("rst_mid_zero", {31'b0, Zero}, 32'd1);
    chk("rst_mid_done", {31'b0, Done}, 32'd0);
    chk("rst_mid_ready", {31'b0, Ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (Done) seen++;
    end
    chk("rst_no_done", seen, 0);

    // Randomised operations.
    for (int i = 0; i < 80; i++) begin
      rop  = 4'($urandom_range(0, 15));
      rsa  = 1'($urandom_range(0, 1));
      rsb  = 1'($urandom_range(0, 1));
      rpc  = $urandom;
      ra   = $urandom;
      rb   = $urandom;
      rimm = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 0;
        1: rb = $urandom_range(1, 40);
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) rimm = rb;
      ea = rsa ? rpc : ra;
      eb = rsb ? rimm : rb;
      do_op(rop, rsa, rsb, rpc, ra, rb, rimm,
            bit'($urandom_range(0, 1)), res, lat);
      chk("rand_res", res, ref_op(rop, ea, eb));
      chk("rand_lat", lat, ref_lat(rop, eb));
    end

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Registered, parametrised ALU for the multi-cycle datapath. It keeps the existing operand muxing (PC/RD1 for A, RD2/ImmExt for B) and the base operation set. It adds shifts, XOR, signed/unsigned compares, and an iterative unsigned multiply/divide unit behind a Start/Done handshake. Results and Zero are registered and held until the next completed operation.

Parameters:
WIDTH, 32, datapath width in bits (power of two, >= 8)
SHW, $clog2(WIDTH), shift-amount bits taken from SrcB[SHW-1:0]

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
Start  input  1  request; accepted only when Ready=1
Ready  output  1  block idle and able to accept Start
PC  input  WIDTH  program counter operand
RD1  input  WIDTH  register operand 1
RD2  input  WIDTH  register operand 2
ImmExt  input  WIDTH  extended immediate
ALUControl  input  4  operation select
ALUSrcA  input  1  1: SrcA=PC, 0: SrcA=RD1
ALUSrcB  input  1  1: SrcB=ImmExt, 0: SrcB=RD2
ALUResult  output  WIDTH  registered result, held between operations
Zero  output  1  registered (ALUResult==0), updated together with ALUResult
Done  output  1  one-cycle pulse: ALUResult/Zero updated this cycle

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE, ALUResult=0, Zero=1, Done=0, Ready=1. Reset mid-operation aborts the operation and discards partial results.
- SrcA and SrcB are muxed combinationally. On acceptance (Start & Ready), the block latches SrcA, SrcB and ALUControl. Later input changes have no effect on the running operation.
- ALUControl encoding:
  - 0000 add
  - 0001 sub
  - 0010 and
  - 0011 or
  - 0100 srl
  - 0101 slt (signed)
  - 0110 pass SrcB
  - 0111 sll
  - 1000 xor
  - 1001 sltu
  - 1010 sra
  - 1011 mul (low WIDTH bits)
  - 1100 mulhu (high WIDTH bits, unsigned)
  - 1101 divu
  - 1110 remu
  - 1111 reserved, result 0
- Arithmetic wraps modulo 2^WIDTH. Shifts use SrcB[SHW-1:0] only. slt and sltu return 1 or 0, zero-extended.
- States: IDLE, MUL, DIV, DONE.
  - IDLE: on accept of a single-cycle op (all except 1011–1110), go to DONE with the result registered. Done=1 the cycle after acceptance (latency 1).
  - IDLE: on accept of 1011/1100, go to MUL with iteration counter=0.
  - IDLE: on accept of 1101/1110 with SrcB!=0, go to DIV with iteration counter=0.
  - IDLE: on accept of 1101/1110 with SrcB==0, go to DONE immediately. divu result is all ones; remu result is SrcA (latency 1).
  - MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit product accumulator. After WIDTH iterations, go to DONE.
  - DIV: restoring division, one quotient bit per cycle. After WIDTH iterations, go to DONE.
  - Latency for mul/div is WIDTH+1 cycles from acceptance to Done.
  - DONE: Done=1 for exactly one cycle, then go to IDLE. ALUResult and Zero keep their values until the next DONE.
- Ready=1 only in IDLE. Start while Ready=0 is ignored, not queued. Start in the cycle immediately after Done is accepted (back-to-back).
- Zero is computed from the value being loaded into ALUResult. It never lags ALUResult by a cycle.

Test Plan:
- Reset asserted mid-MUL (cycle 10 of 32), then released → ALUResult=0, Zero=1, Done=0, Ready=1; no Done pulse follows.
- WIDTH=32, RD1=5, ImmExt=0xFFFFFFFB, ALUSrcB=1, op add → Done one cycle after Start, ALUResult=0, Zero=1.
- RD1=0xFFFFFFFF, RD2=1: slt → 1; sltu → 0. RD1=0x80000000, RD2=4: sra → 0xF8000000; srl → 0x08000000.
- mul 7×6 → Done exactly 33 cycles after Start, ALUResult=42. mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. Start pulsed during busy cycles is ignored; RD1 changed mid-op does not alter the result.
- divu 100/7 → 14, remu 100/7 → 2, each with 33-cycle latency. divu 9/0 → 0xFFFFFFFF with latency 1. remu 9/0 → 9.
- Back-to-back: Start held high across a Done → second op accepted the cycle after Done; ALUResult holds the first result until the second Done.
